// File: rtl/sfifo_param.sv
// Parametrised synchronous FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and a registered read-data valid strobe.
module sfifo_param #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned AF_THRESH = 12,
    parameter int unsigned AE_THRESH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              r_en_i,
    input  logic              err_clr_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              dout_vld_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic [ADDR_W:0]   count_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CW    = ADDR_W + 1;
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);
    localparam logic [CW-1:0] AfC    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AeC    = CW'(AE_THRESH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, empty_q, af_q, ae_q;
    logic [DATA_W-1:0] dout_q;
    logic              dout_vld_q;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              wr_acc, rd_acc;

    // A write into a full FIFO is only legal when a read frees a slot on the same edge.
    always_comb begin
        rd_acc  = r_en_i && !empty_q;
        wr_acc  = w_en_i && (!full_q || rd_acc);
        wptr_d  = wr_acc ? wptr_q + ADDR_W'(1) : wptr_q;
        rptr_d  = rd_acc ? rptr_q + ADDR_W'(1) : rptr_q;
        count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (err_clr_i) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (w_en_i && !wr_acc) ovf_d = 1'b1;
        if (r_en_i && empty_q) udf_d = 1'b1;
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wptr_q] <= din_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            full_q     <= (count_d == DepthC);
            empty_q    <= (count_d == '0);
            af_q       <= (count_d >= AfC);
            ae_q       <= (count_d <= AeC);
            dout_vld_q <= rd_acc;
            if (rd_acc) dout_q <= mem[rptr_q];
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    assign dout_o         = dout_q;
    assign dout_vld_o     = dout_vld_q;
    assign full_o         = full_q;
    assign empty_o        = empty_q;
    assign almost_full_o  = af_q;
    assign almost_empty_o = ae_q;
    assign count_o        = count_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = udf_q;

endmodule

// File: tb/tb_sfifo_param.sv
// Directed bench for sfifo_param at DATA_W=8, ADDR_W=4, AF=12, AE=2.
module tb_sfifo_param;

    logic       clk;
    logic       rst;
    logic       w_en, r_en, err_clr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       dout_vld, full, empty, afull, aempty, ovf, udf;
    logic [4:0] count;

    int checks = 0;
    int passes = 0;

    sfifo_param #(
        .DATA_W(8), .ADDR_W(4), .AF_THRESH(12), .AE_THRESH(2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .w_en_i        (w_en),
        .din_i         (din),
        .r_en_i        (r_en),
        .err_clr_i     (err_clr),
        .dout_o        (dout),
        .dout_vld_o    (dout_vld),
        .full_o        (full),
        .empty_o       (empty),
        .almost_full_o (afull),
        .almost_empty_o(aempty),
        .count_o       (count),
        .overflow_o    (ovf),
        .underflow_o   (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " count"}, 32'(count), 0);
        check({tag, " empty"}, 32'(empty), 1);
        check({tag, " full"}, 32'(full), 0);
        check({tag, " aempty"}, 32'(aempty), 1);
        check({tag, " afull"}, 32'(afull), 0);
        check({tag, " dout"}, 32'(dout), 0);
        check({tag, " vld"}, 32'(dout_vld), 0);
        check({tag, " ovf"}, 32'(ovf), 0);
        check({tag, " udf"}, 32'(udf), 0);
    endtask

    initial begin
        rst = 1'b0; w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0; din = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b1;

        // Fill 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            w_en = 1'b1; din = 8'(i);
            tick();
            check("fill count", 32'(count), 32'(i + 1));
            check("fill afull", 32'(afull), 32'((i + 1) >= 12));
            check("fill aempty", 32'(aempty), 32'((i + 1) <= 2));
            check("fill full", 32'(full), 32'(i == 15));
        end

        // Rejected write at full
        din = 8'hAA;
        tick();
        check("ovf set", 32'(ovf), 1);
        check("ovf count", 32'(count), 16);
        check("ovf full", 32'(full), 1);

        // Drain in order
        w_en = 1'b0; r_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("drain dout", 32'(dout), 32'(i));
            check("drain vld", 32'(dout_vld), 1);
            check("drain count", 32'(count), 32'(15 - i));
        end
        check("drained empty", 32'(empty), 1);
        r_en = 1'b0;
        tick();
        check("idle vld", 32'(dout_vld), 0);
        check("idle dout", 32'(dout), 32'h0F);

        // Underflow then clear
        r_en = 1'b1;
        tick();
        check("udf set", 32'(udf), 1);
        check("udf vld", 32'(dout_vld), 0);
        check("udf dout held", 32'(dout), 32'h0F);
        check("ovf sticky", 32'(ovf), 1);
        r_en = 1'b0; err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr ovf", 32'(ovf), 0);
        check("clr udf", 32'(udf), 0);

        // Streaming across pointer wrap
        w_en = 1'b1; din = 8'h80;
        tick();
        check("prefill count", 32'(count), 1);
        r_en = 1'b1;
        for (int k = 0; k < 100; k++) begin
            din = 8'(8'h81 + k);
            tick();
            check("stream count", 32'(count), 1);
            check("stream vld", 32'(dout_vld), 1);
            check("stream dout", 32'(dout), 32'(8'(8'h80 + k)));
        end
        w_en = 1'b0;
        tick();
        check("stream last", 32'(dout), 32'hE4);
        check("stream empty", 32'(count), 0);
        r_en = 1'b0;
        check("stream ovf", 32'(ovf), 0);
        check("stream udf", 32'(udf), 0);

        // Full with simultaneous read and write
        w_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            din = 8'(8'h40 + i);
            tick();
        end
        check("refill count", 32'(count), 16);
        r_en = 1'b1; din = 8'h99;
        tick();
        check("fullrw count", 32'(count), 16);
        check("fullrw full", 32'(full), 1);
        check("fullrw ovf", 32'(ovf), 0);
        check("fullrw dout", 32'(dout), 32'h40);
        check("fullrw vld", 32'(dout_vld), 1);
        w_en = 1'b0;
        for (int i = 1; i < 16; i++) begin
            tick();
            check("fullrw drain", 32'(dout), 32'(8'h40 + i));
        end
        tick();
        check("fullrw new", 32'(dout), 32'h99);
        check("fullrw empty", 32'(empty), 1);

        // Empty with simultaneous read and write
        w_en = 1'b1; din = 8'h55;
        tick();
        check("emptyrw count", 32'(count), 1);
        check("emptyrw udf", 32'(udf), 1);
        check("emptyrw vld", 32'(dout_vld), 0);
        w_en = 1'b0;
        tick();
        check("emptyrw dout", 32'(dout), 32'h55);
        check("emptyrw vld2", 32'(dout_vld), 1);
        check("emptyrw count2", 32'(count), 0);
        r_en = 1'b0; err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Asynchronous reset with 7 entries held
        w_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din = 8'(8'h10 + i);
            tick();
        end
        w_en = 1'b0; r_en = 1'b1;
        tick();
        r_en = 1'b0;
        check("pre-rst count", 32'(count), 7);
        check("pre-rst dout", 32'(dout), 32'h10);
        #2;
        rst = 1'b0;
        #1;
        check_reset_state("async rst");
        @(negedge clk);
        rst = 1'b1;
        tick();
        w_en = 1'b1; din = 8'h77;
        tick();
        check("post-rst count", 32'(count), 1);
        w_en = 1'b0; r_en = 1'b1;
        tick();
        r_en = 1'b0;
        check("post-rst dout", 32'(dout), 32'h77);
        check("post-rst vld", 32'(dout_vld), 1);
        check("post-rst empty", 32'(empty), 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
